// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and types for the FIFO drain-side stream reader.
package fifo_stream_reader_pkg;

    localparam int BUF_DEPTH = 3;
    localparam int PTR_W     = 2;
    localparam int CNT_W     = 2;

    typedef logic [CNT_W-1:0] buf_count_t;
    typedef logic [PTR_W-1:0] buf_ptr_t;

    // Pointers wrap at BUF_DEPTH, which is not a power of two.
    function automatic buf_ptr_t ptr_next(input buf_ptr_t p);
        return (p == buf_ptr_t'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready output stream of the FIFO stream reader.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 36
);
    logic                  fifo_empty;
    logic                  fifo_oe;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        input  fifo_empty, fifo_dout, m_ready,
        output fifo_oe, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_dout, m_ready,
        input  fifo_oe, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// stream_skid_buf: 3-entry register FIFO absorbing the FIFO RAM read latency.
module stream_skid_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 36
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output buf_count_t            count,
    output logic [DATA_WIDTH-1:0] head_data
);
    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    buf_ptr_t              wr_ptr;
    buf_ptr_t              rd_ptr;

    // Storage is cleared on reset so the head word reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains sync_fifo into a valid/ready stream; define FIFO_STREAM_READER_LAST_EN
// to frame the stream into PKT_LEN-beat packets via m_last.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 36,
    parameter int PKT_LEN    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    fifo_stream_reader_if.master bus,
    output logic [31:0]          xfer_count
);
    buf_count_t count;
    logic       inflight;
    logic       pop;
    logic [2:0] credit_used;

    // Words buffered plus the word still coming out of the RAM bound new reads,
    // so a returning word always finds a free slot without looking at m_ready.
    assign credit_used  = {1'b0, count} + {2'b00, inflight};
    assign bus.fifo_oe  = ~rst & en & ~bus.fifo_empty & (credit_used < 3'(BUF_DEPTH));
    assign bus.m_valid  = (count != '0);
    assign pop          = bus.m_valid & bus.m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight   <= 1'b0;
            xfer_count <= '0;
        end else begin
            inflight <= bus.fifo_oe;
            if (pop) begin
                xfer_count <= xfer_count + 1'b1;
            end
        end
    end

    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (bus.fifo_dout),
        .pop       (pop),
        .count     (count),
        .head_data (bus.m_data)
    );

`ifdef FIFO_STREAM_READER_LAST_EN
    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    logic [BEAT_W-1:0] beat;

    // Beat index of the current head word within its packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat <= '0;
        end else if (pop) begin
            beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
        end
    end

    assign bus.m_last = bus.m_valid & (beat == LAST_BEAT);
`else
    assign bus.m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader with a behavioural FIFO and an in-order scoreboard.
module tb_fifo_stream_reader;
    localparam int DATA_WIDTH = 36;
    localparam int PKT_LEN    = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic [31:0]           xfer_count;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;

    fifo_stream_reader_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

    fifo_stream_reader #(
        .DATA_WIDTH (DATA_WIDTH),
        .PKT_LEN    (PKT_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bus        (bus),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    // Behavioural sync_fifo: registered read data, combinational empty flag.
    logic [DATA_WIDTH-1:0] fmem [512];
    int                    wr_idx;
    int                    rd_idx;
    logic                  underflow;

    assign bus.fifo_empty = (wr_idx == rd_idx);

    initial begin
        for (int i = 0; i < 10; i++) begin
            fmem[i] = DATA_WIDTH'(i);
        end
        wr_idx        = 10;
        rd_idx        = 0;
        underflow     = 1'b0;
        bus.fifo_dout = '0;
        forever begin
            @(posedge clk);
            if (wr_en) begin
                fmem[wr_idx % 512] <= wr_data;
                wr_idx             <= wr_idx + 1;
            end
            if (bus.fifo_oe) begin
                if (wr_idx == rd_idx) underflow <= 1'b1;
                bus.fifo_dout <= fmem[rd_idx % 512];
                rd_idx        <= rd_idx + 1;
            end
        end
    end

    logic [DATA_WIDTH-1:0] exp_q [$];
    int                    hs_cycles [$];
    int                    tests, fails;
    int                    cyc, issued, delivered, oe_pulses, lasts_seen;
    bit                    stalled;
    logic [DATA_WIDTH-1:0] held_data;
    logic                  last_oe;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic rdy, input logic w);
        rst         = r;
        en          = e;
        bus.m_ready = rdy;
        wr_en       = w;
        if (w) begin
            wr_data = {4'($urandom_range(15, 0)), 32'($urandom)};
            exp_q.push_back(wr_data);
        end
    endtask

    task automatic sampleCycle();
        logic hs;
        logic exp_last;
        @(negedge clk);
        hs      = bus.m_valid && bus.m_ready;
        last_oe = bus.fifo_oe;
        if (rst) begin
            checkOutput("rst_fifo_oe", bus.fifo_oe, 0);
            checkOutput("rst_m_valid", bus.m_valid, 0);
            checkOutput("rst_m_data", bus.m_data, 0);
            checkOutput("rst_m_last", bus.m_last, 0);
            checkOutput("rst_xfer_count", xfer_count, 0);
            stalled = 1'b0;
        end else begin
            checkOutput("oe_while_empty", bus.fifo_oe && bus.fifo_empty, 0);
            checkOutput("oe_while_en_low", bus.fifo_oe && !en, 0);
            if (bus.fifo_oe) issued++;
            checkOutput("credit_bound", (issued - delivered) <= 3, 1);
            checkOutput("xfer_count", xfer_count, delivered);
`ifdef FIFO_STREAM_READER_LAST_EN
            exp_last = bus.m_valid && ((delivered % PKT_LEN) == PKT_LEN - 1);
`else
            exp_last = 1'b0;
`endif
            checkOutput("m_last", bus.m_last, exp_last);
            if (stalled) begin
                checkOutput("hold_valid", bus.m_valid, 1);
                checkOutput("hold_data", bus.m_data, held_data);
            end
            if (hs) begin
                checkOutput("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) checkOutput("beat_data", bus.m_data, exp_q.pop_front());
                if (bus.m_last) lasts_seen++;
                delivered++;
                hs_cycles.push_back(cyc);
            end
            stalled   = bus.m_valid && !bus.m_ready;
            held_data = bus.m_data;
            if (bus.fifo_oe) oe_pulses++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic r, input logic e, input logic rdy, input logic w);
        applyStimulus(r, e, rdy, w);
        sampleCycle();
    endtask

    task automatic drainAll();
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
            step(0, 1, 1, 0);
        end
        repeat (3) step(0, 1, 1, 0);
        checkOutput("drained", exp_q.size(), 0);
    endtask

    initial begin
        int rel, stall_p0, idle_p0, wcyc, beat0, exp_lasts;
        tests = 0; fails = 0; cyc = 0; issued = 0; delivered = 0;
        oe_pulses = 0; lasts_seen = 0; stalled = 1'b0; held_data = '0;
        wr_data = '0;
        for (int i = 0; i < 10; i++) exp_q.push_back(DATA_WIDTH'(i));

        // Reset for two cycles with the FIFO already holding 0x0..0x9.
        step(1, 1, 1, 0);
        step(1, 1, 1, 0);
        rel = cyc;
        step(0, 1, 1, 0);
        checkOutput("first_oe_after_release", last_oe, 1);

        // Full-rate streaming of the preloaded words.
        repeat (12) step(0, 1, 1, 0);
        checkOutput("stream_beat_count", hs_cycles.size(), 10);
        if (hs_cycles.size() >= 10) begin
            checkOutput("first_valid_cycle", hs_cycles[0], rel + 2);
            checkOutput("last_beat_cycle", hs_cycles[9], rel + 11);
        end
        checkOutput("xfer_after_stream", xfer_count, 10);

        // Backpressure: consumer stalls for 8 cycles mid-stream.
        stall_p0 = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 6) stall_p0 = oe_pulses;
            if (i == 14) checkOutput("stall_oe_pulses", (oe_pulses - stall_p0) <= 3, 1);
            step(0, 1, !(i >= 6 && i < 14), i < 20);
        end
        drainAll();

        // Empty FIFO, then a single write.
        hs_cycles.delete();
        idle_p0 = oe_pulses;
        repeat (5) step(0, 1, 1, 0);
        checkOutput("idle_oe_pulses", oe_pulses - idle_p0, 0);
        wcyc = cyc;
        step(0, 1, 1, 1);
        repeat (6) step(0, 1, 1, 0);
        checkOutput("single_beat_count", hs_cycles.size(), 1);
        if (hs_cycles.size() == 1) checkOutput("single_beat_cycle", hs_cycles[0], wcyc + 3);
        checkOutput("underflow", underflow, 0);

        // en dropped for 3 cycles mid-stream.
        for (int i = 0; i < 20; i++) begin
            step(0, !(i >= 6 && i < 9), 1, i < 14);
        end
        drainAll();

        // Packet framing with random consumer readiness.
        beat0      = delivered;
        lasts_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 1'($urandom_range(1, 0)), i < 12);
        end
        drainAll();
        exp_lasts = 0;
`ifdef FIFO_STREAM_READER_LAST_EN
        for (int k = beat0; k < beat0 + 12; k++) begin
            if ((k % PKT_LEN) == PKT_LEN - 1) exp_lasts++;
        end
`endif
        checkOutput("lasts_in_run", lasts_seen, exp_lasts);
        checkOutput("final_xfer_count", xfer_count, beat0 + 12);
        checkOutput("final_underflow", underflow, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
